// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  localparam int PS2_DW = 8;

  localparam logic [PS2_DW-1:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [PS2_DW-1:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  // PS/2 uses odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DW-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through FIFO; head is valid combinationally while not empty.
// A push alongside a pop is accepted even when full; otherwise a push into a full FIFO is ignored.
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device receiver with filtered clock, frame checking, timeout and FWFT output FIFO.
// Bytes appear one cycle after the stop-bit strobe; PS2_BREAK_DECODE_EN folds E0/F0 prefixes into flags.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TIMEOUT_US  = 200,
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic                            code_valid,
  output logic [PS2_DW-1:0]               code_data,
`ifdef PS2_BREAK_DECODE_EN
  output logic                            code_ext,
  output logic                            code_break,
`endif
  input  logic                            code_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            busy,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLW = $clog2(FILTER_LEN);
`ifdef PS2_BREAK_DECODE_EN
  localparam int FW = PS2_DW + 2;
`else
  localparam int FW = PS2_DW;
`endif

  logic              clk_m, clk_s, dat_m, dat_s;
  logic              clk_f;
  logic [FLW-1:0]    flt_cnt;
  logic              strobe;

  ps2_state_t        state;
  logic [PS2_DW-1:0] shreg;
  logic [2:0]        bit_idx;
  logic              par_bit;
  logic [TW-1:0]     to_cnt;
  logic              timeout;
  logic              stop_good;

  logic              push;
  logic [FW-1:0]     push_data;
  logic [FW-1:0]     head;
  logic              full;
  logic              empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_m   <= 1'b1;
      clk_s   <= 1'b1;
      dat_m   <= 1'b1;
      dat_s   <= 1'b1;
      clk_f   <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_m <= ps2_clk;
      clk_s <= clk_m;
      dat_m <= ps2_data;
      dat_s <= dat_m;
      if (clk_s == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLW'(FILTER_LEN - 1)) begin
        clk_f   <= clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FLW'(1);
      end
    end
  end

  // Strobe fires in the cycle the filtered clock commits to a falling edge.
  assign strobe    = clk_f && !clk_s && (flt_cnt == FLW'(FILTER_LEN - 1));
  assign timeout   = (state != ST_IDLE) && !strobe && (to_cnt == TW'(TIMEOUT_CYCLES));
  assign stop_good = strobe && (state == ST_STOP) && dat_s && odd_parity_ok(shreg, par_bit);
  assign busy      = (state != ST_IDLE);

`ifdef PS2_BREAK_DECODE_EN
  logic ext_flag, brk_flag;
  logic is_prefix;

  assign is_prefix = (shreg == PS2_PREFIX_EXT) || (shreg == PS2_PREFIX_BRK);
  assign push      = stop_good && !is_prefix;
  assign push_data = {ext_flag, brk_flag, shreg};
  assign {code_ext, code_break, code_data} = head;
`else
  assign push      = stop_good;
  assign push_data = shreg;
  assign code_data = head;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
`endif
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (state == ST_IDLE || strobe || timeout) to_cnt <= '0;
      else                                       to_cnt <= to_cnt + TW'(1);

      if (timeout) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
`endif
      end else if (strobe) begin
        case (state)
          ST_IDLE: begin
            if (!dat_s) begin
              state   <= ST_DATA;
              bit_idx <= '0;
              shreg   <= '0;
            end else begin
              frame_err <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
`endif
            end
          end
          ST_DATA: begin
            shreg   <= {dat_s, shreg[PS2_DW-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= dat_s;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (stop_good) begin
`ifdef PS2_BREAK_DECODE_EN
              if (shreg == PS2_PREFIX_EXT) begin
                ext_flag <= 1'b1;
              end else if (shreg == PS2_PREFIX_BRK) begin
                brk_flag <= 1'b1;
              end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
              end
`endif
            end else begin
              // A bad stop bit outranks a parity failure.
              if (!dat_s) frame_err  <= 1'b1;
              else        parity_err <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= push && full && !(code_ready && code_valid);
  end

  assign code_valid = !empty;

  ps2_sync_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (code_ready),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

endmodule
